cpu_datapath: RTL and testbench

- Execution datapath of the 16-bit RISC CPU. Sits directly downstream of the controller FSM and consumes its per-cycle control strobes.
- Contains an 8x16 register file, operand registers A and B, a shifter, an ALU, result register C and status flags Z/N/V.
- Takes instruction fields from the instruction register, PC from the fetch unit, and read data from RAM. Drives C to the memory address/data path and the flags back to the controller.

---
 rtl/cpu_datapath_if.sv | 50 +++++
 rtl/cpu_datapath.sv | 203 ++++++++++++++++++++
 tb/tb_cpu_datapath.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_datapath_if.sv
// cpu_datapath_if: bundles the controller strobes, instruction/PC/RAM inputs
// and the datapath results into one connection.
// Optional macro STATUS_CARRY_EN adds the carry flag Cf to the bundle.
interface cpu_datapath_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8
);

  logic [15:0]       ir;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] mdata;
  logic [1:0]        reg_sel;
  logic [1:0]        wb_sel;
  logic              w_en;
  logic              en_A;
  logic              en_B;
  logic              en_C;
  logic              en_status;
  logic              sel_A;
  logic              sel_B;
  logic [DATA_W-1:0] datapath_out;
  logic [DATA_W-1:0] rd_data;
  logic              Z;
  logic              N;
  logic              V;
`ifdef STATUS_CARRY_EN
  logic              Cf;
`endif

  // Controller / instruction-side view
  modport master (
    output ir, pc, mdata, reg_sel, wb_sel, w_en,
    output en_A, en_B, en_C, en_status, sel_A, sel_B,
    input  datapath_out, rd_data, Z, N, V
`ifdef STATUS_CARRY_EN
    , input Cf
`endif
  );

  // Datapath view
  modport slave (
    input  ir, pc, mdata, reg_sel, wb_sel, w_en,
    input  en_A, en_B, en_C, en_status, sel_A, sel_B,
    output datapath_out, rd_data, Z, N, V
`ifdef STATUS_CARRY_EN
    , output Cf
`endif
  );

endinterface

// File: rtl/cpu_datapath.sv
// cpu_datapath: execution datapath of the 16-bit RISC CPU.
// 8-entry register file, operand registers A/B, shifter on B, 4-op ALU,
// result register C and status flags Z/N/V.
// Optional macro STATUS_CARRY_EN adds a carry flag Cf (ADD carry-out,
// SUB not-borrow, 0 for logic ops) loaded alongside the other flags.
module cpu_datapath #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8
) (
  input logic           clk,
  input logic           rst,
  cpu_datapath_if.slave bus
);

  localparam int MSB = DATA_W - 1;

  localparam logic [1:0] SEL_RD   = 2'b00;
  localparam logic [1:0] SEL_RM   = 2'b01;
  localparam logic [1:0] SEL_RN   = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  localparam logic [1:0] WB_C     = 2'b00;
  localparam logic [1:0] WB_PC    = 2'b01;
  localparam logic [1:0] WB_IMM8  = 2'b10;
  localparam logic [1:0] WB_MDATA = 2'b11;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  localparam logic [1:0] SH_PASS = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  logic [DATA_W-1:0] regs [8];
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;
  logic [DATA_W-1:0] reg_c;
  logic              flag_z;
  logic              flag_n;
  logic              flag_v;

  logic [2:0]        rf_addr;
  logic [DATA_W-1:0] rf_rdata;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] sximm8;
  logic [DATA_W-1:0] sximm5;
  logic [DATA_W-1:0] shifted_b;
  logic [DATA_W-1:0] ain;
  logic [DATA_W-1:0] bin;
  logic [DATA_W-1:0] alu_res;
  logic              alu_v;
  logic [1:0]        alu_op;
  logic [1:0]        shift_op;
  logic              rf_we;

`ifdef STATUS_CARRY_EN
  logic              alu_c;
  logic              flag_c;
`endif

  // The top instruction bits select the instruction class in the controller only
  logic unused_ir;
  assign unused_ir = ^bus.ir[15:13];

  assign alu_op   = bus.ir[12:11];
  assign shift_op = bus.ir[4:3];
  assign sximm8   = {{(DATA_W-8){bus.ir[7]}}, bus.ir[7:0]};
  assign sximm5   = {{(DATA_W-5){bus.ir[4]}}, bus.ir[4:0]};
  assign rf_we    = bus.w_en && (bus.reg_sel != SEL_NONE);

  // Decode the single register-file address shared by read and write
  always_comb begin
    rf_addr = 3'd0;
    case (bus.reg_sel)
      SEL_RN:  rf_addr = bus.ir[10:8];
      SEL_RM:  rf_addr = bus.ir[2:0];
      SEL_RD:  rf_addr = bus.ir[7:5];
      default: rf_addr = 3'd0;
    endcase
  end

  assign rf_rdata = (bus.reg_sel == SEL_NONE) ? '0 : regs[rf_addr];

  // Select the value written back into the register file
  always_comb begin
    wb_data = '0;
    case (bus.wb_sel)
      WB_C:     wb_data = reg_c;
      WB_PC:    wb_data = {{(DATA_W-PC_W){1'b0}}, bus.pc};
      WB_IMM8:  wb_data = sximm8;
      WB_MDATA: wb_data = bus.mdata;
      default:  wb_data = '0;
    endcase
  end

  // Single-bit shift of operand B ahead of the ALU
  always_comb begin
    shifted_b = reg_b;
    case (shift_op)
      SH_PASS: shifted_b = reg_b;
      SH_LSL:  shifted_b = {reg_b[MSB-1:0], 1'b0};
      SH_LSR:  shifted_b = {1'b0, reg_b[MSB:1]};
      SH_ASR:  shifted_b = {reg_b[MSB], reg_b[MSB:1]};
      default: shifted_b = reg_b;
    endcase
  end

  assign ain = bus.sel_A ? '0 : reg_a;
  assign bin = bus.sel_B ? sximm5 : shifted_b;

  // ALU result plus signed overflow (and carry when enabled) for the flags
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
`ifdef STATUS_CARRY_EN
    alu_c   = 1'b0;
`endif
    case (alu_op)
      OP_ADD: begin
`ifdef STATUS_CARRY_EN
        {alu_c, alu_res} = {1'b0, ain} + {1'b0, bin};
`else
        alu_res = ain + bin;
`endif
        alu_v = (ain[MSB] == bin[MSB]) && (alu_res[MSB] != ain[MSB]);
      end
      OP_SUB: begin
`ifdef STATUS_CARRY_EN
        {alu_c, alu_res} = {1'b0, ain} + {1'b0, ~bin} + {{DATA_W{1'b0}}, 1'b1};
`else
        alu_res = ain - bin;
`endif
        alu_v = (ain[MSB] != bin[MSB]) && (alu_res[MSB] != ain[MSB]);
      end
      OP_AND: alu_res = ain & bin;
      OP_MVN: alu_res = ~bin;
      default: alu_res = '0;
    endcase
  end

  // Register file write; reset clears every entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else if (rf_we) begin
      regs[rf_addr] <= wb_data;
    end
  end

  // Operand registers capture the pre-write register value (no bypass)
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_a <= '0;
      reg_b <= '0;
    end else begin
      if (bus.en_A) reg_a <= rf_rdata;
      if (bus.en_B) reg_b <= rf_rdata;
    end
  end

  // Result register C
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_c <= '0;
    end else if (bus.en_C) begin
      reg_c <= alu_res;
    end
  end

  // Status flags follow the live ALU result, independent of C
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
`ifdef STATUS_CARRY_EN
      flag_c <= 1'b0;
`endif
    end else if (bus.en_status) begin
      flag_z <= (alu_res == '0);
      flag_n <= alu_res[MSB];
      flag_v <= alu_v;
`ifdef STATUS_CARRY_EN
      flag_c <= alu_c;
`endif
    end
  end

  assign bus.datapath_out = reg_c;
  assign bus.rd_data      = rf_rdata;
  assign bus.Z            = flag_z;
  assign bus.N            = flag_n;
  assign bus.V            = flag_v;
`ifdef STATUS_CARRY_EN
  assign bus.Cf           = flag_c;
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: scoreboard bench for cpu_datapath.
// Stimulus drives on the falling edge and queues the expected post-edge
// state from an arithmetic reference model; a monitor checks after each
// rising edge. Define STATUS_CARRY_EN to also check Cf.
module tb_cpu_datapath;

  localparam int DW = 16;
  localparam int PW = 8;

  typedef struct packed {
    logic        rst;
    logic [15:0] ir;
    logic [7:0]  pc;
    logic [15:0] mdata;
    logic [1:0]  reg_sel;
    logic [1:0]  wb_sel;
    logic        w_en;
    logic        en_a;
    logic        en_b;
    logic        en_c;
    logic        en_status;
    logic        sel_a;
    logic        sel_b;
  } stim_t;

  typedef struct packed {
    logic [15:0] tag;
    logic [15:0] dout;
    logic [15:0] rd;
    logic        z;
    logic        n;
    logic        v;
    logic        cf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  cpu_datapath_if #(.DATA_W(DW), .PC_W(PW)) bus ();

  cpu_datapath #(.DATA_W(DW), .PC_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total   = 0;
  int   bad     = 0;
  int   step_no = 0;

  // Reference model state
  int m_regs [8];
  int m_a, m_b, m_c;
  int m_z, m_n, m_v, m_cf;

  function automatic int to_signed16(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.reg_sel = 2'b11;
    return s;
  endfunction

  // Advance the model by one clock using the instruction-set rules
  task automatic modelStep(input stim_t s, output exp_t e);
    int addr, rd_old, shifted, ain, bin, sa, sb, r, res, wb, im;
    int v, c;
    addr = 0;
    case (s.reg_sel)
      2'b10: addr = int'(s.ir[10:8]);
      2'b01: addr = int'(s.ir[2:0]);
      2'b00: addr = int'(s.ir[7:5]);
      default: addr = 0;
    endcase
    rd_old = (s.reg_sel == 2'b11) ? 0 : m_regs[addr];

    case (s.ir[4:3])
      2'b00: shifted = m_b;
      2'b01: shifted = (m_b * 2) % 65536;
      2'b10: shifted = m_b / 2;
      default: begin
        sb = to_signed16(m_b);
        sb = (sb < 0) ? (sb - 1) / 2 : sb / 2;
        shifted = sb & 65535;
      end
    endcase
    im = int'(s.ir[4:0]);
    if (im >= 16) im = im - 32;
    ain = s.sel_a ? 0 : m_a;
    bin = s.sel_b ? (im & 65535) : shifted;
    sa = to_signed16(ain);
    sb = to_signed16(bin);

    v = 0;
    c = 0;
    case (s.ir[12:11])
      2'b00: begin
        r = sa + sb;
        v = (r > 32767 || r < -32768) ? 1 : 0;
        c = (ain + bin > 65535) ? 1 : 0;
        res = r & 65535;
      end
      2'b01: begin
        r = sa - sb;
        v = (r > 32767 || r < -32768) ? 1 : 0;
        c = (ain >= bin) ? 1 : 0;
        res = r & 65535;
      end
      2'b10: res = ain & bin;
      default: res = 65535 - bin;
    endcase

    im = int'(s.ir[7:0]);
    if (im >= 128) im = im - 256;
    case (s.wb_sel)
      2'b00: wb = m_c;
      2'b01: wb = int'(s.pc);
      2'b10: wb = im & 65535;
      default: wb = int'(s.mdata);
    endcase

    if (s.rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 0;
      m_a = 0; m_b = 0; m_c = 0;
      m_z = 0; m_n = 0; m_v = 0; m_cf = 0;
    end else begin
      if (s.w_en && s.reg_sel != 2'b11) m_regs[addr] = wb;
      if (s.en_a) m_a = rd_old;
      if (s.en_b) m_b = rd_old;
      if (s.en_c) m_c = res;
      if (s.en_status) begin
        m_z = (res == 0) ? 1 : 0;
        m_n = (res >= 32768) ? 1 : 0;
        m_v = v;
        m_cf = c;
      end
    end

    e.tag  = 16'(step_no);
    e.dout = 16'(m_c);
    e.rd   = (s.reg_sel == 2'b11) ? 16'h0000 : 16'(m_regs[addr]);
    e.z    = m_z[0];
    e.n    = m_n[0];
    e.v    = m_v[0];
    e.cf   = m_cf[0];
  endtask

  // Drive one cycle of inputs on the falling edge and return its expectation
  task automatic applyStimulus(input stim_t s, output exp_t e);
    @(negedge clk);
    rst           = s.rst;
    bus.ir        = s.ir;
    bus.pc        = s.pc;
    bus.mdata     = s.mdata;
    bus.reg_sel   = s.reg_sel;
    bus.wb_sel    = s.wb_sel;
    bus.w_en      = s.w_en;
    bus.en_A      = s.en_a;
    bus.en_B      = s.en_b;
    bus.en_C      = s.en_c;
    bus.en_status = s.en_status;
    bus.sel_A     = s.sel_a;
    bus.sel_B     = s.sel_b;
    modelStep(s, e);
    step_no++;
  endtask

  task automatic checkOutput(input int tag, input string what,
                             input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL step %0d %s: got %h expected %h", tag, what, act, req);
    end
  endtask

  // Monitor: after each rising edge, compare the DUT against the oldest expectation
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checkOutput(int'(mon_e.tag), "datapath_out", bus.datapath_out, mon_e.dout);
        checkOutput(int'(mon_e.tag), "rd_data", bus.rd_data, mon_e.rd);
        checkOutput(int'(mon_e.tag), "Z", {15'd0, bus.Z}, {15'd0, mon_e.z});
        checkOutput(int'(mon_e.tag), "N", {15'd0, bus.N}, {15'd0, mon_e.n});
        checkOutput(int'(mon_e.tag), "V", {15'd0, bus.V}, {15'd0, mon_e.v});
`ifdef STATUS_CARRY_EN
        checkOutput(int'(mon_e.tag), "Cf", {15'd0, bus.Cf}, {15'd0, mon_e.cf});
`endif
      end
    end
  end

  // Stimulus: directed scenarios with spec constants, then random traffic
  initial begin
    stim_t s;
    exp_t  e;

    s = idle();
    rst = 1'b1;
    bus.ir = '0; bus.pc = '0; bus.mdata = '0;
    bus.reg_sel = 2'b11; bus.wb_sel = '0; bus.w_en = 1'b0;
    bus.en_A = 1'b0; bus.en_B = 1'b0; bus.en_C = 1'b0; bus.en_status = 1'b0;
    bus.sel_A = 1'b0; bus.sel_B = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
    m_a = 0; m_b = 0; m_c = 0; m_z = 0; m_n = 0; m_v = 0; m_cf = 0;

    // Reset
    s = idle(); s.rst = 1'b1;
    applyStimulus(s, e);
    e.dout = 16'h0000; e.rd = 16'h0000; e.z = 1'b0; e.n = 1'b0; e.v = 1'b0;
    exp_q.push_back(e);

    // MOV R3, #0x85 -> sign-extended 0xFF85
    s = idle(); s.ir = 16'h0385; s.reg_sel = 2'b10; s.wb_sel = 2'b10; s.w_en = 1'b1;
    applyStimulus(s, e);
    e.rd = 16'hFF85;
    exp_q.push_back(e);

    // R1=5, R2=3, A<-R1, B<-R2, ADD with LSL1 -> 5 + 6
    s = idle(); s.ir = 16'h0105; s.reg_sel = 2'b10; s.wb_sel = 2'b10; s.w_en = 1'b1;
    applyStimulus(s, e); exp_q.push_back(e);
    s.ir = 16'h0203;
    applyStimulus(s, e); exp_q.push_back(e);
    s = idle(); s.ir = 16'h0100; s.reg_sel = 2'b10; s.en_a = 1'b1;
    applyStimulus(s, e); exp_q.push_back(e);
    s = idle(); s.ir = 16'h0200; s.reg_sel = 2'b10; s.en_b = 1'b1;
    applyStimulus(s, e); exp_q.push_back(e);
    s = idle(); s.ir = 16'h0008; s.en_c = 1'b1;
    applyStimulus(s, e);
    e.dout = 16'h000B;
    exp_q.push_back(e);

    // CMP 0x7FFF - 0xFFFF: overflow into negative, C untouched
    s = idle(); s.ir = 16'h0080; s.reg_sel = 2'b00; s.wb_sel = 2'b11; s.mdata = 16'h7FFF; s.w_en = 1'b1;
    applyStimulus(s, e); exp_q.push_back(e);
    s = idle(); s.ir = 16'h05FF; s.reg_sel = 2'b10; s.wb_sel = 2'b10; s.w_en = 1'b1;
    applyStimulus(s, e); exp_q.push_back(e);
    s = idle(); s.ir = 16'h0080; s.reg_sel = 2'b00; s.en_a = 1'b1;
    applyStimulus(s, e); exp_q.push_back(e);
    s = idle(); s.ir = 16'h0500; s.reg_sel = 2'b10; s.en_b = 1'b1;
    applyStimulus(s, e); exp_q.push_back(e);
    s = idle(); s.ir = 16'h0800; s.en_status = 1'b1;
    applyStimulus(s, e);
    e.dout = 16'h000B; e.z = 1'b0; e.n = 1'b1; e.v = 1'b1;
    exp_q.push_back(e);

    // LDR writeback into R6, then a suppressed write with reg_sel=none
    s = idle(); s.ir = 16'h00C0; s.reg_sel = 2'b00; s.wb_sel = 2'b11; s.mdata = 16'hBEEF; s.w_en = 1'b1;
    applyStimulus(s, e);
    e.rd = 16'hBEEF;
    exp_q.push_back(e);
    s.reg_sel = 2'b11; s.mdata = 16'h1234;
    applyStimulus(s, e);
    e.rd = 16'h0000;
    exp_q.push_back(e);
    s = idle(); s.ir = 16'h00C0; s.reg_sel = 2'b00;
    applyStimulus(s, e);
    e.rd = 16'hBEEF;
    exp_q.push_back(e);

    // R7=0x11, then BL writes pc while A captures the old R7
    s = idle(); s.ir = 16'h0711; s.reg_sel = 2'b10; s.wb_sel = 2'b10; s.w_en = 1'b1;
    applyStimulus(s, e); exp_q.push_back(e);
    s = idle(); s.ir = 16'h0700; s.reg_sel = 2'b10; s.wb_sel = 2'b01; s.pc = 8'h2A;
    s.w_en = 1'b1; s.en_a = 1'b1;
    applyStimulus(s, e);
    e.rd = 16'h002A;
    exp_q.push_back(e);
    s = idle(); s.ir = 16'h0000; s.sel_b = 1'b1; s.en_c = 1'b1;
    applyStimulus(s, e);
    e.dout = 16'h0011;
    exp_q.push_back(e);

    // Reset wins over simultaneous en_C and w_en
    s = idle(); s.rst = 1'b1; s.ir = 16'h0711; s.reg_sel = 2'b10; s.wb_sel = 2'b10;
    s.w_en = 1'b1; s.en_c = 1'b1; s.en_status = 1'b1;
    applyStimulus(s, e);
    e.dout = 16'h0000; e.rd = 16'h0000; e.z = 1'b0; e.n = 1'b0; e.v = 1'b0;
    exp_q.push_back(e);

    // SUB 5-3 then 3-5 (carry = not borrow when enabled)
    s = idle(); s.ir = 16'h0105; s.reg_sel = 2'b10; s.wb_sel = 2'b10; s.w_en = 1'b1;
    applyStimulus(s, e); exp_q.push_back(e);
    s.ir = 16'h0203;
    applyStimulus(s, e); exp_q.push_back(e);
    s = idle(); s.ir = 16'h0100; s.reg_sel = 2'b10; s.en_a = 1'b1;
    applyStimulus(s, e); exp_q.push_back(e);
    s = idle(); s.ir = 16'h0200; s.reg_sel = 2'b10; s.en_b = 1'b1;
    applyStimulus(s, e); exp_q.push_back(e);
    s = idle(); s.ir = 16'h0800; s.en_status = 1'b1; s.en_c = 1'b1;
    applyStimulus(s, e);
    e.dout = 16'h0002; e.z = 1'b0; e.n = 1'b0; e.v = 1'b0; e.cf = 1'b1;
    exp_q.push_back(e);
    s = idle(); s.ir = 16'h0200; s.reg_sel = 2'b10; s.en_a = 1'b1;
    applyStimulus(s, e); exp_q.push_back(e);
    s = idle(); s.ir = 16'h0100; s.reg_sel = 2'b10; s.en_b = 1'b1;
    applyStimulus(s, e); exp_q.push_back(e);
    s = idle(); s.ir = 16'h0800; s.en_status = 1'b1; s.en_c = 1'b1;
    applyStimulus(s, e);
    e.dout = 16'hFFFE; e.z = 1'b0; e.n = 1'b1; e.v = 1'b0; e.cf = 1'b0;
    exp_q.push_back(e);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      s.rst       = ($urandom_range(0, 63) == 0);
      s.ir        = 16'($urandom);
      s.pc        = 8'($urandom);
      s.mdata     = 16'($urandom);
      s.reg_sel   = 2'($urandom_range(0, 3));
      s.wb_sel    = 2'($urandom_range(0, 3));
      s.w_en      = 1'($urandom_range(0, 1));
      s.en_a      = 1'($urandom_range(0, 1));
      s.en_b      = 1'($urandom_range(0, 1));
      s.en_c      = 1'($urandom_range(0, 1));
      s.en_status = 1'($urandom_range(0, 1));
      s.sel_a     = ($urandom_range(0, 3) == 0);
      s.sel_b     = ($urandom_range(0, 3) == 0);
      applyStimulus(s, e);
      exp_q.push_back(e);
    end

    // Drain the scoreboard within a bounded number of cycles
    s = idle();
    @(negedge clk);
    bus.w_en = 1'b0; bus.en_A = 1'b0; bus.en_B = 1'b0; bus.en_C = 1'b0; bus.en_status = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: pending=%0d required=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
